// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the control sequencer.
//   - 5-bit opcode constants (IR[31:27])
//   - sequencer state enumeration
//   - ALU operation encodings driven on alu_op
package cpu_pkg;

   localparam int unsigned OPCODE_W = 5;

   localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPCODE_W-1:0] OP_BR   = 5'b10010;
   localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH0 = 4'd1,
      S_FETCH1 = 4'd2,
      S_FETCH2 = 4'd3,
      S_EXEC3  = 4'd4,
      S_EXEC4  = 4'd5,
      S_EXEC5  = 4'd6,
      S_EXEC6  = 4'd7,
      S_EXEC7  = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3
   } alu_op_t;

   // Opcodes that run through the EXEC states; all others return to FETCH0.
   function automatic logic has_exec(input logic [OPCODE_W-1:0] op);
      case (op)
         OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_BR: has_exec = 1'b1;
         default:                                                    has_exec = 1'b0;
      endcase
   endfunction

   function automatic alu_op_t alu_for(input logic [OPCODE_W-1:0] op);
      case (op)
         OP_SUB:  alu_for = ALU_SUB;
         OP_AND:  alu_for = ALU_AND;
         OP_OR:   alu_for = ALU_OR;
         default: alu_for = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for a simple bus-based CPU.
// Ports:
//   clock, clear (async active-low reset)
//   IR[31:0]        instruction register, opcode in IR[31:27]
//   CON_FF          branch condition flag
//   mem_ready       memory access completes this cycle
//   stop            halt request, sampled in FETCH0
//   PCout, MDRout, Zlowout, Cout          bus-drive enables
//   MARin, MDRin, IRin, PCin, Yin, Zin, CONin  register load enables
//   IncPC, Read, Write                    PC increment / memory strobes
//   Gra, Grb, Grc, Rin, Rout, BAout        register select/encode controls
//   alu_op[3:0]     ALU operation
//   Run             high while fetching/executing
module control_sequencer
   import cpu_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        mem_ready,
   input  logic        stop,
   output logic        PCout,
   output logic        MDRout,
   output logic        Zlowout,
   output logic        Cout,
   output logic        MARin,
   output logic        MDRin,
   output logic        IRin,
   output logic        PCin,
   output logic        Yin,
   output logic        Zin,
   output logic        CONin,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic [3:0]  alu_op,
   output logic        Run
);

   state_t               state, state_next;
   logic [OPCODE_W-1:0]  opcode_q;
   logic [OPCODE_W-1:0]  ir_op;
   alu_op_t              alu_sel;
   logic                 ir_unused;

   assign ir_op     = IR[31:27];
   // Only the opcode field steers sequencing.
   assign ir_unused = ^IR[26:0];
   assign alu_op    = alu_sel;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state    <= S_RESET;
         opcode_q <= '0;
      end else begin
         state <= state_next;
         if (state == S_FETCH2) begin
            opcode_q <= ir_op;
         end
      end
   end

   // Outputs decode from state; the only input-qualified strobes are PCin in
   // FETCH1 (mem_ready) and in br EXEC6 (CON_FF), Zlowout likewise for br.
   always_comb begin
      state_next = state;
      PCout   = 1'b0;
      MDRout  = 1'b0;
      Zlowout = 1'b0;
      Cout    = 1'b0;
      MARin   = 1'b0;
      MDRin   = 1'b0;
      IRin    = 1'b0;
      PCin    = 1'b0;
      Yin     = 1'b0;
      Zin     = 1'b0;
      CONin   = 1'b0;
      IncPC   = 1'b0;
      Read    = 1'b0;
      Write   = 1'b0;
      Gra     = 1'b0;
      Grb     = 1'b0;
      Grc     = 1'b0;
      Rin     = 1'b0;
      Rout    = 1'b0;
      BAout   = 1'b0;
      alu_sel = ALU_ADD;
      Run     = (state != S_RESET) && (state != S_HALT);

      case (state)
         S_RESET: state_next = S_FETCH0;

         S_FETCH0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
            state_next = stop ? S_HALT : S_FETCH1;
         end

         S_FETCH1: begin
            Zlowout = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            if (mem_ready) begin
               PCin       = 1'b1;
               state_next = S_FETCH2;
            end
         end

         // The branch out of FETCH2 uses the opcode being latched this cycle,
         // so the decision comes from IR directly rather than opcode_q.
         S_FETCH2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
            if (ir_op == OP_HALT) begin
               state_next = S_HALT;
            end else if (has_exec(ir_op)) begin
               state_next = S_EXEC3;
            end else begin
               state_next = S_FETCH0;
            end
         end

         S_EXEC3: begin
            state_next = S_EXEC4;
            Rout = 1'b1;
            case (opcode_q)
               OP_LD, OP_ST: begin
                  Grb   = 1'b1;
                  BAout = 1'b1;
                  Yin   = 1'b1;
               end
               OP_BR: begin
                  Gra   = 1'b1;
                  CONin = 1'b1;
               end
               default: begin
                  Grb = 1'b1;
                  Yin = 1'b1;
               end
            endcase
         end

         S_EXEC4: begin
            state_next = S_EXEC5;
            case (opcode_q)
               OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  Grc     = 1'b1;
                  Rout    = 1'b1;
                  Zin     = 1'b1;
                  alu_sel = alu_for(opcode_q);
               end
               OP_BR: begin
                  PCout = 1'b1;
                  Yin   = 1'b1;
               end
               default: begin
                  Cout = 1'b1;
                  Zin  = 1'b1;
               end
            endcase
         end

         S_EXEC5: begin
            case (opcode_q)
               OP_LD, OP_ST: begin
                  Zlowout    = 1'b1;
                  MARin      = 1'b1;
                  state_next = S_EXEC6;
               end
               OP_BR: begin
                  Cout       = 1'b1;
                  Zin        = 1'b1;
                  state_next = S_EXEC6;
               end
               default: begin
                  Zlowout    = 1'b1;
                  Gra        = 1'b1;
                  Rin        = 1'b1;
                  state_next = S_FETCH0;
               end
            endcase
         end

         S_EXEC6: begin
            case (opcode_q)
               OP_LD: begin
                  Read  = 1'b1;
                  MDRin = 1'b1;
                  if (mem_ready) state_next = S_EXEC7;
               end
               OP_ST: begin
                  Gra        = 1'b1;
                  Rout       = 1'b1;
                  MDRin      = 1'b1;
                  state_next = S_EXEC7;
               end
               default: begin
                  Zlowout    = CON_FF;
                  PCin       = CON_FF;
                  state_next = S_FETCH0;
               end
            endcase
         end

         S_EXEC7: begin
            if (opcode_q == OP_LD) begin
               MDRout     = 1'b1;
               Gra        = 1'b1;
               Rin        = 1'b1;
               state_next = S_FETCH0;
            end else begin
               Write = 1'b1;
               if (mem_ready) state_next = S_FETCH0;
            end
         end

         S_HALT: state_next = S_HALT;

         default: state_next = S_RESET;
      endcase
   end

endmodule
